load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Memory-access stage directly downstream of the ALU. Takes the ALU sum (load/store
//   effective address) plus rs2 data, runs one data-memory transaction over a req/ack
//   handshake, and returns a sign/zero-extended load result to writeback.
//   Holds the core via busy while a transaction is in flight. A timeout aborts a
//   transaction that never receives ack.
// PARAMETERS
//   TIMEOUT_CYCLES  255  max cycles in REQ without mem_ack before bus_err; range 2..65535
// PORTS
//   clk        in   1   core clock, all state on rising edge
//   rst        in   1   synchronous, active-high reset
//   start      in   1   transaction request; accepted only when busy=0
//   is_store   in   1   1=store, 0=load
//   funct3     in   3   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr       in   32  effective address (ALU result)
//   wdata      in   32  store data (rs2), low bits used for B/H
//   busy       out  1   high in every state except IDLE
//   done       out  1   one-cycle completion pulse
//   rdata      out  32  extended load data; valid with done, held until next done
//   misalign   out  1   with done: misaligned address or illegal funct3, no bus access
//   bus_err    out  1   with done: timeout expired
//   mem_req    out  1   memory request, held until mem_ack
//   mem_we     out  1   1=write
//   mem_addr   out  32  {addr[31:2],2'b00}
//   mem_be     out  4   byte enables (writes); 4'b0000 on reads
//   mem_wdata  out  32  lane-shifted store data
//   mem_ack    in   1   completion; sampled only in REQ
//   mem_rdata  in   32  read word, valid when mem_ack=1
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, misalign, bus_err, mem_req, mem_we = 0; rdata, mem_addr,
//     mem_be, mem_wdata, timeout counter = 0. rst mid-transaction -> IDLE next edge,
//     mem_req drops; memory must tolerate an abandoned request.
//   FSM IDLE/REQ/RESP:
//   - IDLE: start=1 registers is_store, funct3, addr, wdata. Fault check: H/HU with
//     addr[0]=1, W with addr[1:0]!=0, load funct3 in {011,110,111}, store funct3 >010.
//     Fault -> RESP with misalign=1. Otherwise -> REQ, counter cleared.
//   - REQ: mem_req=1. mem_we, mem_addr, mem_be, mem_wdata come from registered values
//     and stay stable until ack. mem_ack=1 -> capture mem_rdata -> RESP.
//     Otherwise the counter increments. Counter==TIMEOUT_CYCLES-1 with no ack -> RESP
//     with bus_err=1. Ack in the timeout cycle wins: no error.
//   - RESP: done=1 for exactly one cycle, then IDLE. rdata updates only on a successful
//     load; stores, misalign and bus_err leave rdata unchanged. start is ignored while
//     busy=1; it is seen in IDLE the cycle after RESP.
//   Latency: start@T -> mem_req@T+1 -> with ack@T+1, done@T+2. Faulted start -> done@T+1.
//   Lanes, off=addr[1:0]: SB be=4'b0001<<off, data=wdata[7:0]<<8*off; SH be=4'b0011<<off,
//     data=wdata[15:0]<<8*off; SW be=4'b1111, data=wdata.
//   Loads: field = mem_rdata>>8*off. B/H sign-extend bit 7/15; BU/HU zero-extend; W as-is.
//   mem_ack outside REQ is ignored.
// STRUCTURE
//   Shared package/include lsu_defs: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//     and 2-bit state encodings (S_IDLE, S_REQ, S_RESP).
//   Sub-module lsu_lane_align (combinational): off, funct3, wdata, mem_rdata ->
//     mem_be, mem_wdata, extended load value, fault flag. Top holds FSM, regs, counter.
// TESTING
//   1 Reset mid-REQ: assert rst while mem_req=1 -> next cycle mem_req=0, busy=0, state IDLE.
//   2 LW addr=0x100, mem_rdata=0xDEADBEEF, ack on first REQ cycle -> mem_addr=0x100,
//     mem_be=0, done two cycles after start, rdata=0xDEADBEEF.
//   3 LB addr=0x103, mem_rdata=0x80FF0000 -> rdata=0xFFFFFF80. LBU gives 0x00000080.
//     LHU addr=0x102 gives 0x000080FF.
//   4 SH addr=0x202, wdata=0x1234ABCD -> mem_we=1, mem_addr=0x200, be=4'b1100,
//     mem_wdata=0xABCD0000. SB addr=0x201 -> be=4'b0010, data=0x0000CD00.
//   5 LW addr=0x102 -> no mem_req, done+misalign on the cycle after start, rdata unchanged.
//     SW with funct3=011 also gives misalign.
//   6 TIMEOUT_CYCLES=4, ack never asserted -> mem_req high 4 cycles, then done+bus_err,
//     busy falls. Repeat with ack on the 4th cycle -> no bus_err.
//     A start pulse while busy is ignored (no second transaction).

Source files
------------

// File: rtl/lsu_defs.sv
// Shared load/store unit definitions: funct3 size/sign codes and FSM state encoding.
package lsu_defs;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, load-field extraction/extension, and access legality check.
module lsu_lane_align
   import lsu_defs::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic        is_store,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   output logic [31:0] load_data,
   output logic        fault
);

   logic [4:0]  shift;
   logic [31:0] field;

   assign shift = {off, 3'b000};
   assign field = mem_rdata >> shift;

   always_comb begin
      mem_be    = 4'b0000;
      mem_wdata = wdata;
      load_data = field;
      fault     = 1'b0;
      case (funct3)
         F3_B: begin
            mem_be    = 4'b0001 << off;
            mem_wdata = {24'b0, wdata[7:0]} << shift;
            load_data = {{24{field[7]}}, field[7:0]};
         end
         F3_H: begin
            mem_be    = 4'b0011 << off;
            mem_wdata = {16'b0, wdata[15:0]} << shift;
            load_data = {{16{field[15]}}, field[15:0]};
            fault     = off[0];
         end
         F3_W: begin
            mem_be    = 4'b1111;
            load_data = mem_rdata;
            fault     = (off != 2'b00);
         end
         // Unsigned variants exist only for loads.
         F3_BU: begin
            load_data = {24'b0, field[7:0]};
            fault     = is_store;
         end
         F3_HU: begin
            load_data = {16'b0, field[15:0]};
            fault     = is_store | off[0];
         end
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per start, with
// alignment checking, byte-lane steering, load extension and an ack timeout.
module load_store_unit
   import lsu_defs::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state_q, state_d;
   logic        is_store_q, is_store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;
   logic [15:0] cnt_q, cnt_d;

   logic        in_idle;
   logic [1:0]  lane_off;
   logic [2:0]  lane_funct3;
   logic        lane_store;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] lane_load;
   logic        lane_fault;

   // In IDLE the aligner judges the incoming request; afterwards it serves the registered one.
   assign in_idle     = (state_q == S_IDLE);
   assign lane_off    = in_idle ? addr[1:0] : addr_q[1:0];
   assign lane_funct3 = in_idle ? funct3    : funct3_q;
   assign lane_store  = in_idle ? is_store  : is_store_q;

   lsu_lane_align u_lane_align (
      .off       (lane_off),
      .funct3    (lane_funct3),
      .is_store  (lane_store),
      .wdata     (wdata_q),
      .mem_rdata (mem_rdata),
      .mem_be    (lane_be),
      .mem_wdata (lane_wdata),
      .load_data (lane_load),
      .fault     (lane_fault)
   );

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      misalign_d = misalign_q;
      bus_err_d  = bus_err_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_store_d = is_store;
               funct3_d   = funct3;
               addr_d     = addr;
               wdata_d    = wdata;
               misalign_d = lane_fault;
               bus_err_d  = 1'b0;
               cnt_d      = 16'd0;
               state_d    = lane_fault ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               if (!is_store_q) rdata_d = lane_load;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               bus_err_d = 1'b1;
               state_d   = S_RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         is_store_q <= 1'b0;
         funct3_q   <= 3'b000;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         cnt_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         funct3_q   <= funct3_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign busy      = !in_idle;
   assign done      = (state_q == S_RESP);
   assign misalign  = done & misalign_q;
   assign bus_err   = done & bus_err_q;
   assign rdata     = rdata_q;
   assign mem_req   = (state_q == S_REQ);
   assign mem_we    = mem_req & is_store_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_be    = (mem_req && is_store_q) ? lane_be : 4'b0000;
   assign mem_wdata = mem_req ? lane_wdata : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        misalign;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int          total  = 0;
   int          passed = 0;
   int          failed = 0;
   logic [31:0] model_rdata = 32'd0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_store  (is_store),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .misalign  (misalign),
      .bus_err   (bus_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
      int f   = int'(f3);
      int off = int'(a % 4);
      if (st && f > 2) return 1'b1;
      if (!st && (f == 3 || f == 6 || f == 7)) return 1'b1;
      if ((f == 1 || f == 5) && (off % 2) != 0) return 1'b1;
      if (f == 2 && off != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
      int off = int'(a % 4);
      if (!st) return 4'd0;
      if (f3 == 3'd0) return 4'(1 << off);
      if (f3 == 3'd1) return 4'(3 << off);
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] wd);
      int          off = int'(a % 4);
      logic [31:0] v;
      if (f3 == 3'd0) v = wd % 256;
      else if (f3 == 3'd1) v = wd % 65536;
      else return wd;
      return v << (8 * off);
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w);
      int          off = int'(a % 4);
      logic [31:0] sh  = w >> (8 * off);
      logic [31:0] v;
      case (f3)
         3'd0: begin v = sh % 256;   if (v >= 128)   v = v - 256;   end
         3'd1: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
         3'd4: v = sh % 256;
         3'd5: v = sh % 65536;
         default: v = w;
      endcase
      return v;
   endfunction

   // ack_dly: REQ cycle index on which ack is given (-1 = never); start_at: REQ cycle to pulse start.
   task automatic run_txn(input string tag, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                          input int ack_dly, input int start_at);
      bit flt = m_fault(st, f3, a);
      int cyc = 0;
      bit exp_err;
      int exp_cyc;
      is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
      step();
      start = 1'b0; is_store = ~st; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      if (flt) begin
         chk({tag, ".flt_done"}, 32'(done), 32'd1);
         chk({tag, ".flt_misalign"}, 32'(misalign), 32'd1);
         chk({tag, ".flt_req"}, 32'(mem_req), 32'd0);
         chk({tag, ".flt_rdata"}, rdata, model_rdata);
         step();
         chk({tag, ".flt_busy"}, 32'(busy), 32'd0);
         return;
      end
      chk({tag, ".req"}, 32'(mem_req), 32'd1);
      chk({tag, ".we"}, 32'(mem_we), 32'(st));
      chk({tag, ".be"}, 32'(mem_be), 32'(m_be(st, f3, a)));
      if (st) chk({tag, ".wdata"}, mem_wdata, m_wdata(f3, a, wd));
      while (mem_req === 1'b1 && cyc < 20) begin
         chk({tag, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
         if (cyc == ack_dly) begin mem_ack = 1'b1; mem_rdata = rw; end
         else begin mem_ack = 1'b0; mem_rdata = $urandom; end
         start = (cyc == start_at);
         step();
         mem_ack = 1'b0; start = 1'b0;
         cyc++;
      end
      exp_err = !(ack_dly >= 0 && ack_dly < TO);
      exp_cyc = exp_err ? TO : ack_dly + 1;
      if (!exp_err && !st) model_rdata = m_load(f3, a, rw);
      chk({tag, ".req_cycles"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".bus_err"}, 32'(bus_err), 32'(exp_err));
      chk({tag, ".misalign"}, 32'(misalign), 32'd0);
      chk({tag, ".rdata"}, rdata, model_rdata);
      step();
      chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
      chk({tag, ".idle_req"}, 32'(mem_req), 32'd0);
      chk({tag, ".idle_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
      wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      step(); step();
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.misalign", 32'(misalign), 32'd0);
      chk("rst.bus_err", 32'(bus_err), 32'd0);
      chk("rst.req", 32'(mem_req), 32'd0);
      chk("rst.we", 32'(mem_we), 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      chk("rst.addr", mem_addr, 32'd0);
      chk("rst.be", 32'(mem_be), 32'd0);
      chk("rst.wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      step();

      // Reset while a request is outstanding.
      is_store = 1'b0; funct3 = 3'd2; addr = 32'h40; start = 1'b1;
      step();
      start = 1'b0;
      chk("midrst.req_before", 32'(mem_req), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_rdata = 32'd0;
      chk("midrst.req", 32'(mem_req), 32'd0);
      chk("midrst.busy", 32'(busy), 32'd0);
      chk("midrst.done", 32'(done), 32'd0);
      step();

      run_txn("lw", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, -1);
      run_txn("lb", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF0000, 0, -1);
      chk("lb.value", rdata, 32'hFFFFFF80);
      run_txn("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 1, -1);
      chk("lbu.value", rdata, 32'h00000080);
      run_txn("lhu", 1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF0000, 0, -1);
      chk("lhu.value", rdata, 32'h000080FF);
      run_txn("sh", 1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0, 0, -1);
      run_txn("sb", 1'b1, 3'd0, 32'h201, 32'h1234ABCD, 32'h0, 2, -1);
      run_txn("lw_mis", 1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0, -1);
      run_txn("sw_f3", 1'b1, 3'd3, 32'h300, 32'h0, 32'h0, 0, -1);
      run_txn("timeout", 1'b0, 3'd2, 32'h400, 32'h0, 32'h11111111, -1, -1);
      run_txn("ack_last", 1'b0, 3'd2, 32'h404, 32'h0, 32'h22222222, TO - 1, -1);
      run_txn("busy_start", 1'b0, 3'd1, 32'h406, 32'h0, 32'h7FFF0000, 2, 1);

      // Ack while idle must be ignored.
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_ack = 1'b0;
      chk("idle_ack.done", 32'(done), 32'd0);
      chk("idle_ack.busy", 32'(busy), 32'd0);
      chk("idle_ack.rdata", rdata, model_rdata);

      for (int i = 0; i < 40; i++) begin
         bit          r_st  = 1'($urandom);
         logic [2:0]  r_f3  = 3'($urandom);
         logic [31:0] r_a   = $urandom;
         logic [31:0] r_wd  = $urandom;
         logic [31:0] r_rw  = $urandom;
         int          r_dly = int'($urandom_range(0, 5)) - 1;
         run_txn("rand", r_st, r_f3, r_a, r_wd, r_rw, r_dly, -1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
